mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
- MEM-stage consumer of the EXE stage outputs: takes ALU_result as the data address, Val_Rm as store data, and the MEM_R_EN/MEM_W_EN controls.
- Performs 32-bit loads and stores on an external 16-bit asynchronous SRAM as two half-word accesses, each lasting a fixed number of wait cycles.
- Drops ready low to freeze the pipeline for the duration of each access.

Parameters:
- WAIT_CYCLES, 2, cycles each half-word access is held on the SRAM bus (legal range 1..15).
- MEM_BASE, 1024, byte address subtracted from ALU_result to form the SRAM offset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- MEM_R_EN  input  1  load request from the EXE/MEM pipeline register.
- MEM_W_EN  input  1  store request from the EXE/MEM pipeline register.
- ALU_result  input  32  byte address from EXE.
- Val_Rm  input  32  store data.
- ready  output  1  low = freeze the pipeline.
- read_data  output  32  load result.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_DQ  inout  16  SRAM data bus; driven only while writing, otherwise high-Z.
- SRAM_WE_N  output  1  SRAM write enable, active-low.

Behaviour:
- Address mapping:
  - off = ALU_result - MEM_BASE, computed modulo 2^32.
  - waddr = off[18:2]; off[1:0] is ignored and off[31:19] is truncated.
  - Low half-word lives at {waddr,1'b0}, high half-word at {waddr,1'b1}.
- FSM states: IDLE, ACC_LO, ACC_HI, DONE.
  - IDLE: if MEM_R_EN|MEM_W_EN, latch op (write wins if both are set), waddr and Val_Rm, clear the counter, go to ACC_LO. Otherwise stay.
  - ACC_LO: SRAM_ADDR = {waddr,0}. Counter increments each cycle. When counter == WAIT_CYCLES-1, clear the counter and go to ACC_HI.
  - ACC_HI: same as ACC_LO with SRAM_ADDR = {waddr,1}; at the terminal count go to DONE.
  - DONE: stays one cycle, then goes unconditionally to IDLE.
- ready (combinational):
  - IDLE: ~(MEM_R_EN|MEM_W_EN).
  - ACC_LO, ACC_HI: 0.
  - DONE: 1.
  - With a request, ready is low for exactly 1+2*WAIT_CYCLES cycles, then high for one cycle (DONE), during which the pipeline advances.
  - The next request is seen in the following IDLE cycle, so back-to-back requests each pay the full latency.
- Writes:
  - SRAM_WE_N = 0 for every cycle of ACC_LO/ACC_HI on a write op; 1 otherwise.
  - SRAM_DQ carries latched data[15:0] in ACC_LO and data[31:16] in ACC_HI; it is high-Z in every other state and for reads.
- Reads:
  - read_data[15:0] is captured from SRAM_DQ on the terminal-count edge of ACC_LO; read_data[31:16] on the terminal-count edge of ACC_HI.
  - read_data holds its value until the next read overwrites it. Writes never modify read_data.
- Inputs are sampled only in IDLE. Changes during an access are ignored; the latched op, address and data are used.
- In IDLE with no request, SRAM_ADDR holds its last value and SRAM_WE_N = 1.
- Reset (any state, including mid-access), applied at the next edge:
  - state = IDLE, counter = 0, SRAM_ADDR = 0, SRAM_WE_N = 1, SRAM_DQ high-Z, read_data = 0.
  - A write interrupted by reset may leave the low half-word written; this is acceptable.
- Counter width: 4 bits.

Test Plan:
- Store, WAIT_CYCLES=2: MEM_W_EN=1, ALU_result=1024, Val_Rm=0xDEADBEEF.
  - ready low cycles 0–4 and high in cycle 5.
  - SRAM word 0 = 0xBEEF and word 1 = 0xDEAD.
  - SRAM_WE_N low for exactly 4 cycles; SRAM_DQ high-Z in cycle 5.
- Load: SRAM words 6/7 preloaded with 0x5678/0x1234. MEM_R_EN=1, ALU_result=1036.
  - SRAM_ADDR = 6 then 7.
  - read_data = 0x12345678 in cycle 5 and held afterward; SRAM_WE_N stays 1.
- Back-to-back: store to 1028, then load from 1028 in the next IDLE.
  - Two separate 6-cycle windows; IDLE ready is low in the second window's first cycle.
  - Load returns the stored value.
- Input change mid-access: start a store of 0xAAAA5555 to 1032, then change Val_Rm/ALU_result during ACC_LO.
  - Words 4/5 = 0x5555/0xAAAA; the new values are ignored.
- Reset mid-access: assert rst during ACC_HI of a read.
  - Next cycle: ready follows the request, SRAM_WE_N = 1, SRAM_DQ = Z, read_data = 0, SRAM_ADDR = 0.
  - After release, a new read completes normally.
- Wrap/alignment: ALU_result=1027 accesses word 0; ALU_result=1020 wraps to waddr=0x1FFFF (SRAM_ADDR 0x3FFFE/0x3FFFF).
  - With both enables set, a write is performed.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage SRAM controller: 32-bit loads/stores as two half-word accesses on a
// 16-bit asynchronous SRAM, holding the pipeline frozen while the access runs.
`timescale 1ns/1ps
module mem_stage_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MEM_BASE    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Val_Rm,
    output logic        ready,
    output logic [31:0] read_data,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WADR_W = 17;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [WADR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         data_q, data_d;
    logic [17:0]         addr_q, addr_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [WADR_W-1:0]   req_waddr;
    logic                req;
    logic                last;
    logic                in_acc;
    logic                drive;

    // Word index of the incoming byte address relative to the SRAM window.
    assign req_waddr = WADR_W'((ALU_result - 32'(MEM_BASE)) >> 2);
    assign req       = MEM_R_EN | MEM_W_EN;
    assign last      = (cnt_q == CNT_LAST);
    assign in_acc    = (state_q == ACC_LO) || (state_q == ACC_HI);
    assign drive     = wr_q && in_acc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    wr_d    = MEM_W_EN;
                    waddr_d = req_waddr;
                    data_d  = Val_Rm;
                    cnt_d   = '0;
                    addr_d  = {req_waddr, 1'b0};
                    state_d = ACC_LO;
                end
            end
            ACC_LO: begin
                if (last) begin
                    cnt_d   = '0;
                    addr_d  = {waddr_q, 1'b1};
                    state_d = ACC_HI;
                    if (!wr_q) rdata_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACC_HI: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!wr_q) rdata_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus controls decode directly from registered state; no extra latency.
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = ~drive;
    assign SRAM_DQ   = drive ? ((state_q == ACC_LO) ? data_q[15:0] : data_q[31:16]) : 16'hzzzz;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed and random loads/stores against a
// word-level reference memory, with a behavioural async SRAM on the bus.
`timescale 1ns/1ps
module tb_mem_stage_sram_ctrl;

    localparam int unsigned W    = 2;
    localparam int unsigned BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_result, Val_Rm;
    logic        ready;
    logic [31:0] read_data;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .MEM_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_result(ALU_result), .Val_Rm(Val_Rm), .ready(ready),
        .read_data(read_data), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
        .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // Async SRAM: drives the bus whenever not being written.
    bit [15:0] sram_mem [0:262143];
    assign SRAM_DQ = SRAM_WE_N ? sram_mem[SRAM_ADDR] : 16'hzzzz;
    always @(negedge clk) if (!SRAM_WE_N) sram_mem[SRAM_ADDR] = SRAM_DQ;

    // Reference: 32-bit words keyed by word index, plus last load result.
    logic [31:0] exp_word [logic [16:0]];
    logic [31:0] exp_rd;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [16:0] wa);
        return exp_word.exists(wa) ? exp_word[wa] : 32'h0;
    endfunction

    // One access from an IDLE cycle; inputs cleared after DONE.
    task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit scramble);
        logic [31:0] off = addr - 32'(BASE);
        logic [16:0] wa  = off[18:2];
        MEM_R_EN = rd; MEM_W_EN = wr; ALU_result = addr; Val_Rm = data;
        @(negedge clk);
        chk("req_ready", 32'(ready), 32'h0);
        chk("rd_hold", read_data, exp_rd);
        for (int c = 1; c <= 2 * int'(W); c++) begin
            @(posedge clk); #1;
            if (scramble && c == 1) begin
                ALU_result = $urandom; Val_Rm = $urandom;
            end
            @(negedge clk);
            chk("acc_ready", 32'(ready), 32'h0);
            chk("acc_addr", 32'(SRAM_ADDR), 32'({wa, (c > int'(W)) ? 1'b1 : 1'b0}));
            chk("acc_we_n", 32'(SRAM_WE_N), wr ? 32'h0 : 32'h1);
            if (wr) chk("acc_dq", 32'(SRAM_DQ), (c <= int'(W)) ? 32'(data[15:0]) : 32'(data[31:16]));
        end
        if (wr) exp_word[wa] = data;
        else    exp_rd = ref_word(wa);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_ready", 32'(ready), 32'h1);
        chk("done_we_n", 32'(SRAM_WE_N), 32'h1);
        chk("done_rdata", read_data, exp_rd);
        chk("done_dq_z", 32'(SRAM_DQ), 32'(sram_mem[SRAM_ADDR]));
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    initial begin
        bit r, w;
        logic [31:0] a;
        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = '0; Val_Rm = '0;
        exp_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
        chk("rst_we_n", 32'(SRAM_WE_N), 32'h1);
        @(posedge clk); #1;

        // Store then idle hold
        run_op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
        chk("st_word0", 32'(sram_mem[0]), 32'hBEEF);
        chk("st_word1", 32'(sram_mem[1]), 32'hDEAD);
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'h1);
        chk("idle_addr_hold", 32'(SRAM_ADDR), 32'h1);
        chk("idle_we_n", 32'(SRAM_WE_N), 32'h1);
        @(posedge clk); #1;

        // Load of preloaded words 6/7
        sram_mem[6] = 16'h5678; sram_mem[7] = 16'h1234; exp_word[17'd3] = 32'h12345678;
        run_op(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
        chk("ld_value", exp_rd, 32'h12345678);

        // Back-to-back store/load
        run_op(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b0);
        run_op(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        chk("b2b_value", read_data, 32'hCAFEF00D);

        // Inputs changing mid-access are ignored
        run_op(1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 1'b1);
        chk("mid_word4", 32'(sram_mem[4]), 32'h5555);
        chk("mid_word5", 32'(sram_mem[5]), 32'hAAAA);

        // Reset during ACC_HI of a read
        MEM_R_EN = 1'b1; ALU_result = 32'd1036;
        repeat (int'(W) + 1) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        chk("mrst_ready", 32'(ready), 32'h0);
        chk("mrst_we_n", 32'(SRAM_WE_N), 32'h1);
        chk("mrst_dq_z", 32'(SRAM_DQ), 32'(sram_mem[SRAM_ADDR]));
        chk("mrst_rdata", read_data, 32'h0);
        chk("mrst_addr", 32'(SRAM_ADDR), 32'h0);
        MEM_R_EN = 1'b0;
        @(posedge clk); #1;
        run_op(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

        // Alignment and wrap; both enables means write
        run_op(1'b1, 1'b0, 32'd1027, 32'h0, 1'b0);
        chk("align_word0", read_data, 32'hDEADBEEF);
        run_op(1'b1, 1'b1, 32'd1020, 32'h0BADC0DE, 1'b0);
        chk("wrap_lo", 32'(sram_mem[18'h3FFFE]), 32'hC0DE);
        chk("wrap_hi", 32'(sram_mem[18'h3FFFF]), 32'h0BAD);
        chk("wrap_rd_kept", read_data, 32'hDEADBEEF);

        // Random traffic, mostly in a small window to force read-after-write hits
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            a = ($urandom_range(0, 3) == 0) ? $urandom
                : 32'(BASE) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            run_op(r, w, a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
